reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Write-back receiver and architectural register file for vcpu1.
- Accepts the selected write-back word (ALU / load / mov / jump-return result), commits it to the GPRs and serves two combinational read ports to decode.
- Holds a per-register pending-write scoreboard, set at issue and cleared at commit, so decode can detect RAW hazards.

Parameters:
- DW, 32, data width of a register.
- REG_AW, 5, register address width; NREGS = 2**REG_AW.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wb_valid  in  1  write-back slot valid this cycle.
- wb_we  in  1  instruction writes a GPR (0 for st, jumps without link, nop).
- wb_waddr  in  REG_AW  destination register.
- wb_wdata  in  DW  selected write-back data.
- rd_addr1  in  REG_AW  read port 1 address.
- rd_addr2  in  REG_AW  read port 2 address.
- rd_data1  out  DW  read port 1 data.
- rd_data2  out  DW  read port 2 data.
- iss_valid  in  1  an instruction issues this cycle.
- iss_we  in  1  issuing instruction will write a GPR.
- iss_dst  in  REG_AW  its destination.
- busy1  out  1  rd_addr1 has an uncommitted pending write.
- busy2  out  1  rd_addr2 has an uncommitted pending write.
- pend_cnt  out  REG_AW+1  number of registers currently pending.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset:
  - On a rising edge with rst_n=0, all GPRs, all pending bits and pend_cnt clear to 0.
  - While rst_n=0, rd_data1/2, busy1/2 and pend_cnt read 0.
  - Reset overrides any simultaneous write or issue, including mid write-back.
- Commit:
  - Condition: wb_valid & wb_we & (wb_waddr != 0).
  - Effect: GPR[wb_waddr] <= wb_wdata at the edge, and the pending bit for wb_waddr clears.
  - wb_we=0 or wb_valid=0: no state change.
  - wb_waddr=0: the write is dropped.
- r0: reads always return 0. r0 is never marked pending.
- Read (combinational, zero latency):
  - rd_dataN = GPR[rd_addrN], subject to the bypass rule under Optional Feature.
  - rd_addr1 == rd_addr2 is legal; both ports return the same value.
- Scoreboard set:
  - Condition: iss_valid & iss_we & (iss_dst != 0).
  - Effect: sets pending[iss_dst] at the edge.
- Simultaneous issue and commit to the same register in one cycle: the set wins and the register stays pending, because a new producer is in flight.
- Simultaneous issue and commit to different registers: both take effect.
- Issue to an already-pending register: the bit stays 1. There is no counting per register; the pipeline is in-order, so the youngest writer commits last.
- busyN = pending[rd_addrN], from registered state only. A commit in the current cycle does not clear busy until the next cycle unless bypass is enabled.
- pend_cnt:
  - Registered popcount of the pending bits, updated every edge.
  - Range 0..NREGS-1; it can never overflow because r0 is excluded.

Optional Feature:
- Macro: REG_FILE_WB_BYPASS_EN.
- Defined:
  - Write-through forwarding. If a commit (as defined above) is present this cycle and wb_waddr == rd_addrN != 0, then rd_dataN = wb_wdata.
  - busyN is forced 0 when that same commit targets rd_addrN, unless an issue to rd_addrN occurs in the same cycle.
- Undefined:
  - Reads return the pre-edge GPR value, and busy stays asserted through the commit cycle.
  - Decode must stall one extra cycle.

Decomposition:
- Shared package/include (instr_syntax-style header):
  - REG_AW, DW, NREGS.
  - REG_ZERO = 0.
- Natural sub-module: reg_scoreboard.
  - Contents: pending bit vector, set/clear priority, busy lookups, pend_cnt.
- The parent holds the GPR array, the read muxes and the bypass logic.

Test Plan:
- Reset: write r5=0x1234 with rst_n=0 -> r5 reads 0, pend_cnt=0. Release reset, commit r5=0x1234 -> next cycle rd_addr1=5 reads 0x00001234.
- r0: commit wb_waddr=0, wdata=0xFFFFFFFF; issue iss_dst=0 -> rd_data1(0)=0, busy1=0, pend_cnt unchanged.
- Scoreboard: issue r3 -> busy1(r3)=1, pend_cnt=1. Two cycles later commit r3=0xA5A5A5A5 -> busy1=0 and pend_cnt=0 the next cycle.
- Simultaneous set/clear on r7: pending r7, then issue r7 and commit r7=0x77 in the same cycle -> r7 reads 0x77, busy stays 1, pend_cnt=1.
- Bypass, with REG_FILE_WB_BYPASS_EN: commit r9=0xDEADBEEF while rd_addr2=9 -> rd_data2=0xDEADBEEF in the same cycle, busy2=0.
  - Without the macro: old value in that cycle, busy2=1, then new value and busy2=0 one cycle later.
- wb_we=0: wb_valid=1, wb_we=0, waddr=4, wdata=0x55 with r4 pending -> r4 value unchanged and r4 stays pending.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the vcpu1 register file and write-back receiver.
// Default geometry: 32 registers of 32 bits, r0 hard-wired to zero.
package reg_file_wb_pkg;

   localparam int unsigned DW       = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NREGS    = 2 ** REG_AW;
   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/reg_file_wb_scoreboard.sv
// Pending-write scoreboard: one bit per GPR, set at issue, cleared at commit.
// busy lookups and pend_cnt come from registered state only.
module reg_scoreboard #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic [REG_AW-1:0] rd_addr1,
   input  logic [REG_AW-1:0] rd_addr2,
   output logic              busy1,
   output logic              busy2,
   output logic [REG_AW:0]   pend_cnt
);

   localparam int unsigned NREGS = 2 ** REG_AW;

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_nxt;
   logic [REG_AW:0]  cnt_q;

   // Clear is applied before set so a same-cycle issue keeps the register pending.
   always_comb begin
      pending_nxt = pending;
      if (clr_en) pending_nxt[clr_idx] = 1'b0;
      if (set_en) pending_nxt[set_idx] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
         cnt_q   <= '0;
      end else begin
         pending <= pending_nxt;
         cnt_q   <= (REG_AW+1)'($countones(pending_nxt));
      end
   end

   assign busy1    = pending[rd_addr1];
   assign busy2    = pending[rd_addr2];
   assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_wb.sv
// vcpu1 write-back receiver, GPR array and two combinational read ports.
// Optional macro REG_FILE_WB_BYPASS_EN enables write-through forwarding to reads and busy.
module reg_file_wb #(
   parameter int unsigned DW     = reg_file_wb_pkg::DW,
   parameter int unsigned REG_AW = reg_file_wb_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_waddr,
   input  logic [DW-1:0]     wb_wdata,
   input  logic [REG_AW-1:0] rd_addr1,
   input  logic [REG_AW-1:0] rd_addr2,
   output logic [DW-1:0]     rd_data1,
   output logic [DW-1:0]     rd_data2,
   input  logic              iss_valid,
   input  logic              iss_we,
   input  logic [REG_AW-1:0] iss_dst,
   output logic              busy1,
   output logic              busy2,
   output logic [REG_AW:0]   pend_cnt
);

   import reg_file_wb_pkg::*;

   localparam int unsigned NREGS_L = 2 ** REG_AW;
   localparam logic [REG_AW-1:0] R0 = REG_AW'(REG_ZERO);

   logic [DW-1:0]   gpr [NREGS_L];
   logic            commit;
   logic            issue;
   logic            sb_busy1;
   logic            sb_busy2;
   logic [REG_AW:0] sb_cnt;

   assign commit = wb_valid & wb_we & (wb_waddr != R0);
   assign issue  = iss_valid & iss_we & (iss_dst != R0);

   reg_scoreboard #(
      .REG_AW (REG_AW)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue),
      .set_idx  (iss_dst),
      .clr_en   (commit),
      .clr_idx  (wb_waddr),
      .rd_addr1 (rd_addr1),
      .rd_addr2 (rd_addr2),
      .busy1    (sb_busy1),
      .busy2    (sb_busy2),
      .pend_cnt (sb_cnt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gpr <= '{default: '0};
      end else if (commit) begin
         gpr[wb_waddr] <= wb_wdata;
      end
   end

   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      busy1    = 1'b0;
      busy2    = 1'b0;
      pend_cnt = '0;
      if (rst_n) begin
         if (rd_addr1 != R0) rd_data1 = gpr[rd_addr1];
         if (rd_addr2 != R0) rd_data2 = gpr[rd_addr2];
         busy1    = sb_busy1;
         busy2    = sb_busy2;
         pend_cnt = sb_cnt;
`ifdef REG_FILE_WB_BYPASS_EN
         // commit already excludes r0, so a match implies a non-zero read address
         if (commit && (wb_waddr == rd_addr1)) begin
            rd_data1 = wb_wdata;
            if (!(issue && (iss_dst == rd_addr1))) busy1 = 1'b0;
         end
         if (commit && (wb_waddr == rd_addr2)) begin
            rd_data2 = wb_wdata;
            if (!(issue && (iss_dst == rd_addr2))) busy2 = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb; expectations follow REG_FILE_WB_BYPASS_EN.
`timescale 1ns/1ps
module tb_reg_file_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic [4:0]  rd_addr1, rd_addr2;
   logic [31:0] rd_data1, rd_data2;
   logic        iss_valid, iss_we;
   logic [4:0]  iss_dst;
   logic        busy1, busy2;
   logic [5:0]  pend_cnt;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   reg_file_wb #(
      .DW     (32),
      .REG_AW (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .rd_data1  (rd_data1),
      .rd_data2  (rd_data2),
      .iss_valid (iss_valid),
      .iss_we    (iss_we),
      .iss_dst   (iss_dst),
      .busy1     (busy1),
      .busy2     (busy2),
      .pend_cnt  (pend_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid  = 1'b0;
      wb_we     = 1'b0;
      wb_waddr  = '0;
      wb_wdata  = '0;
      iss_valid = 1'b0;
      iss_we    = 1'b0;
      iss_dst   = '0;
   endtask

   task automatic set_wb(input logic [4:0] a, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_we    = 1'b1;
      wb_waddr = a;
      wb_wdata = d;
   endtask

   task automatic set_iss(input logic [4:0] a);
      iss_valid = 1'b1;
      iss_we    = 1'b1;
      iss_dst   = a;
   endtask

   initial begin
      idle();
      rst_n    = 1'b0;
      rd_addr1 = 5'd5;
      rd_addr2 = 5'd6;

      // write and issue both attempted while reset is held
      set_wb(5'd5, 32'h0000_1234);
      set_iss(5'd6);
      tick();
      tick();
      check_eq("rst_rd1", rd_data1, 32'h0);
      check_eq("rst_busy2", 32'(busy2), 32'h0);
      check_eq("rst_cnt", 32'(pend_cnt), 32'h0);
      rst_n = 1'b1;
      idle();
      #1;
      check_eq("post_rst_r5", rd_data1, 32'h0);
      check_eq("post_rst_cnt", 32'(pend_cnt), 32'h0);

      set_wb(5'd5, 32'h0000_1234);
      tick();
      idle();
      check_eq("r5_commit", rd_data1, 32'h0000_1234);

      // r0 write and issue must be ignored
      rd_addr1 = 5'd0;
      set_wb(5'd0, 32'hFFFF_FFFF);
      set_iss(5'd0);
      tick();
      idle();
      check_eq("r0_rd", rd_data1, 32'h0);
      check_eq("r0_busy", 32'(busy1), 32'h0);
      check_eq("r0_cnt", 32'(pend_cnt), 32'h0);

      // scoreboard set and clear on r3
      rd_addr1 = 5'd3;
      set_iss(5'd3);
      tick();
      idle();
      check_eq("r3_busy", 32'(busy1), 32'h1);
      check_eq("r3_cnt", 32'(pend_cnt), 32'h1);
      tick();
      set_wb(5'd3, 32'hA5A5_A5A5);
      #1;
`ifdef REG_FILE_WB_BYPASS_EN
      check_eq("r3_wb_rd", rd_data1, 32'hA5A5_A5A5);
      check_eq("r3_wb_busy", 32'(busy1), 32'h0);
`else
      check_eq("r3_wb_rd", rd_data1, 32'h0);
      check_eq("r3_wb_busy", 32'(busy1), 32'h1);
`endif
      tick();
      idle();
      check_eq("r3_after_rd", rd_data1, 32'hA5A5_A5A5);
      check_eq("r3_after_busy", 32'(busy1), 32'h0);
      check_eq("r3_after_cnt", 32'(pend_cnt), 32'h0);

      // same-cycle set and clear on r7: set wins
      rd_addr1 = 5'd7;
      set_iss(5'd7);
      tick();
      idle();
      set_iss(5'd7);
      set_wb(5'd7, 32'h0000_0077);
      #1;
      check_eq("r7_sc_busy", 32'(busy1), 32'h1);
`ifdef REG_FILE_WB_BYPASS_EN
      check_eq("r7_sc_rd", rd_data1, 32'h0000_0077);
`else
      check_eq("r7_sc_rd", rd_data1, 32'h0);
`endif
      tick();
      idle();
      check_eq("r7_rd", rd_data1, 32'h0000_0077);
      check_eq("r7_busy", 32'(busy1), 32'h1);
      check_eq("r7_cnt", 32'(pend_cnt), 32'h1);

      // issue r8 while committing r7: both apply
      rd_addr2 = 5'd8;
      set_iss(5'd8);
      set_wb(5'd7, 32'h0000_0078);
      tick();
      idle();
      check_eq("r7r8_rd1", rd_data1, 32'h0000_0078);
      check_eq("r7r8_busy1", 32'(busy1), 32'h0);
      check_eq("r7r8_busy2", 32'(busy2), 32'h1);
      check_eq("r7r8_cnt", 32'(pend_cnt), 32'h1);

      // commit visibility on read port 2
      rd_addr2 = 5'd9;
      set_wb(5'd9, 32'h1111_1111);
      tick();
      idle();
      set_iss(5'd9);
      tick();
      idle();
      check_eq("r9_cnt", 32'(pend_cnt), 32'h2);
      set_wb(5'd9, 32'hDEAD_BEEF);
      #1;
`ifdef REG_FILE_WB_BYPASS_EN
      check_eq("r9_wb_rd", rd_data2, 32'hDEAD_BEEF);
      check_eq("r9_wb_busy", 32'(busy2), 32'h0);
`else
      check_eq("r9_wb_rd", rd_data2, 32'h1111_1111);
      check_eq("r9_wb_busy", 32'(busy2), 32'h1);
`endif
      tick();
      idle();
      check_eq("r9_rd", rd_data2, 32'hDEAD_BEEF);
      check_eq("r9_busy", 32'(busy2), 32'h0);
      check_eq("r9_cnt_after", 32'(pend_cnt), 32'h1);

      // non-writing write-back slots leave r4 pending and unchanged
      rd_addr1 = 5'd4;
      set_iss(5'd4);
      tick();
      idle();
      check_eq("r4_cnt", 32'(pend_cnt), 32'h2);
      wb_valid = 1'b1;
      wb_we    = 1'b0;
      wb_waddr = 5'd4;
      wb_wdata = 32'h0000_0055;
      #1;
      check_eq("r4_we0_busy_now", 32'(busy1), 32'h1);
      tick();
      idle();
      check_eq("r4_we0_rd", rd_data1, 32'h0);
      check_eq("r4_we0_busy", 32'(busy1), 32'h1);
      wb_valid = 1'b0;
      wb_we    = 1'b1;
      wb_waddr = 5'd4;
      wb_wdata = 32'h0000_0066;
      tick();
      idle();
      check_eq("r4_v0_rd", rd_data1, 32'h0);
      check_eq("r4_v0_cnt", 32'(pend_cnt), 32'h2);

      // re-issue to a pending register does not double count
      set_iss(5'd4);
      tick();
      idle();
      check_eq("r4_reiss_cnt", 32'(pend_cnt), 32'h2);

      // same address on both ports
      rd_addr1 = 5'd7;
      rd_addr2 = 5'd7;
      #1;
      check_eq("same_rd1", rd_data1, 32'h0000_0078);
      check_eq("same_rd2", rd_data2, 32'h0000_0078);

      // reset mid write-back
      rst_n = 1'b0;
      set_wb(5'd7, 32'h0000_0099);
      #1;
      check_eq("midrst_cnt_now", 32'(pend_cnt), 32'h0);
      check_eq("midrst_rd_now", rd_data1, 32'h0);
      tick();
      rst_n = 1'b1;
      idle();
      rd_addr2 = 5'd8;
      #1;
      check_eq("midrst_r7", rd_data1, 32'h0);
      check_eq("midrst_busy_r8", 32'(busy2), 32'h0);
      check_eq("midrst_cnt", 32'(pend_cnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
